// File: rtl/fifo_upsizer_pkg.sv
// Shared helpers for the FIFO read-side upsizer (and its matching downsizer).
package fifo_upsizer_pkg;

  localparam int unsigned MAX_LANES = 64;

  // Lane index width; at least one bit even for two lanes.
  function automatic int unsigned lane_idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Mask with the low 'count' bits set; callers truncate to their lane count.
  function automatic logic [MAX_LANES-1:0] keep_mask(input int unsigned count);
    logic [MAX_LANES-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      if (i < count) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/upsizer_out_reg.sv
// Single-entry valid/ready holding register carrying data plus a keep mask.
module upsizer_out_reg #(
  parameter int unsigned DW = 32,
  parameter int unsigned KW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic [DW-1:0] i_data,
  input  logic [KW-1:0] i_keep,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic [KW-1:0] o_keep,
  output logic          o_free_c
);

  // Slot can take a new beat when empty or being drained this cycle.
  assign o_free_c = ~o_valid | i_ready;

  // Load a new beat, drop valid after a transfer, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_keep  <= '0;
    end else if (i_load) begin
      o_valid <= 1'b1;
      o_data  <= i_data;
      o_keep  <= i_keep;
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_rd_upsizer.sv
// Pops W-bit words from a FWFT FIFO and packs N of them into one wide beat.
module fifo_rd_upsizer
  import fifo_upsizer_pkg::*;
#(
  parameter int unsigned W = 8,
  parameter int unsigned N = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           fifo_rd_empty,
  input  logic [W-1:0]   fifo_rd_data,
  output logic           fifo_rd_en,
  input  logic           flush,
  output logic           out_valid,
  output logic [N*W-1:0] out_data,
  output logic [N-1:0]   out_keep,
  input  logic           out_ready
);

  localparam int unsigned IW = lane_idx_w(N);
  localparam int unsigned CW = IW + 1;
  localparam int unsigned DW = N * W;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  logic [W-1:0]  r_lanes [N];
  logic [IW-1:0] r_idx;
  logic          r_flush_pend;

  logic          w_free;
  logic          w_stall;
  logic          w_pop;
  logic          w_full;
  logic          w_flush_req;
  logic          w_flush_serve;
  logic          w_load;
  logic [CW-1:0] w_cnt;
  logic [DW-1:0] w_beat_data;
  logic [N-1:0]  w_beat_keep;

  // Pop unless empty, in reset, or the last lane would have nowhere to go.
  assign w_stall       = (r_idx == LAST_IDX) & ~w_free;
  assign w_pop         = ~fifo_rd_empty & ~w_stall & ~reset;
  assign fifo_rd_en    = w_pop;
  assign w_full        = w_pop & (r_idx == LAST_IDX);
  assign w_flush_req   = flush | r_flush_pend;
  assign w_flush_serve = w_flush_req & w_free & ((r_idx != '0) | w_pop);
  assign w_load        = w_full | w_flush_serve;
  assign w_cnt         = CW'(r_idx) + CW'(w_pop);
  assign w_beat_keep   = N'(keep_mask(32'(w_cnt)));

  // Merge assembled lanes with this cycle's word; unfilled lanes read as zero.
  always_comb begin
    w_beat_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (CW'(i) < w_cnt) begin
        w_beat_data[i*W +: W] = (w_pop && (r_idx == IW'(i))) ? fifo_rd_data : r_lanes[i];
      end
    end
  end

  // Assembly lanes, fill index and pending-flush flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx        <= '0;
      r_flush_pend <= 1'b0;
      for (int unsigned i = 0; i < N; i++) r_lanes[i] <= '0;
    end else begin
      if (w_load) begin
        r_idx <= '0;
      end else if (w_pop) begin
        r_lanes[r_idx] <= fifo_rd_data;
        r_idx          <= r_idx + IW'(1);
      end
      // Cleared when served, or dropped when there is nothing to close.
      r_flush_pend <= w_flush_req & ~w_load & ~((r_idx == '0) & ~w_pop);
    end
  end

  upsizer_out_reg #(
    .DW (DW),
    .KW (N)
  ) u_out_reg (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_load),
    .i_data   (w_beat_data),
    .i_keep   (w_beat_keep),
    .i_ready  (out_ready),
    .o_valid  (out_valid),
    .o_data   (out_data),
    .o_keep   (out_keep),
    .o_free_c (w_free)
  );

endmodule

// File: tb/tb_fifo_rd_upsizer.sv
// Scoreboarded bench for fifo_rd_upsizer (W=8, N=4).
module tb_fifo_rd_upsizer;

  logic        clk;
  logic        reset;
  logic        fifo_rd_empty;
  logic [7:0]  fifo_rd_data;
  logic        fifo_rd_en;
  logic        flush;
  logic        out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  fifo_q[$];
  logic [7:0]  sb[$];
  logic [31:0] got_data[$];
  logic [3:0]  got_keep[$];

  int          cyc = 0;
  int          pops = 0;
  int          last_pop_cyc = -1;
  int          first_valid_cyc = -1;
  bit          first_valid_seen = 0;
  bit          prev_hold = 0;
  logic [31:0] prev_data;
  logic [3:0]  prev_keep;
  logic        last_rd_en;

  fifo_rd_upsizer #(.W(8), .N(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .fifo_rd_empty (fifo_rd_empty),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_rd_en    (fifo_rd_en),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_keep      (out_keep),
    .out_ready     (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: drive at negedge, sample before posedge, update FIFO model after it.
  task automatic drive_cycle(input bit gate, input bit rdy, input bit fl, input bit rst);
    logic [31:0] d;
    logic [3:0]  k;
    logic        v;
    logic        en;
    logic [7:0]  exp_w;
    reset         = rst;
    out_ready     = rdy;
    flush         = fl;
    fifo_rd_empty = gate || (fifo_q.size() == 0);
    fifo_rd_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    #1;
    en = fifo_rd_en; v = out_valid; d = out_data; k = out_keep;
    last_rd_en = en;
    n_checks++;
    if (en && fifo_rd_empty) begin
      n_fail++;
      $display("FAIL pop_while_empty cyc %0d: fifo_rd_en=%b required 0", cyc, en);
    end
    if (rst) begin
      n_checks++;
      if (en !== 1'b0) begin
        n_fail++;
        $display("FAIL rd_en_in_reset cyc %0d: fifo_rd_en=%b required 0", cyc, en);
      end
    end
    if (prev_hold) begin
      n_checks++;
      if (v !== 1'b1 || d !== prev_data || k !== prev_keep) begin
        n_fail++;
        $display("FAIL stall_stable cyc %0d: valid=%b data=%h keep=%b required 1 %h %b",
                 cyc, v, d, k, prev_data, prev_keep);
      end
    end
    prev_hold = v && !rdy && !rst;
    prev_data = d;
    prev_keep = k;
    if (v === 1'b1 && !first_valid_seen) begin
      first_valid_seen = 1;
      first_valid_cyc  = cyc;
    end
    if (v === 1'b1 && rdy) begin
      got_data.push_back(d);
      got_keep.push_back(k);
      n_checks++;
      if (k == 4'b0000 || (((k + 4'd1) & k) != 4'b0000)) begin
        n_fail++;
        $display("FAIL keep_contig cyc %0d: keep=%b required contiguous from lane 0", cyc, k);
      end
      for (int i = 0; i < 4; i++) begin
        if (k[i]) begin
          n_checks++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_underflow cyc %0d lane %0d: got %h required no data", cyc, i, d[i*8 +: 8]);
          end else begin
            exp_w = sb.pop_front();
            if (d[i*8 +: 8] !== exp_w) begin
              n_fail++;
              $display("FAIL sb_data cyc %0d lane %0d: got %h required %h", cyc, i, d[i*8 +: 8], exp_w);
            end
          end
        end
      end
    end
    @(posedge clk);
    if (en === 1'b1) begin
      sb.push_back(fifo_q[0]);
      void'(fifo_q.pop_front());
      pops++;
      last_pop_cyc = cyc;
    end
    if (rst) sb.delete();
    cyc++;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    fifo_q.delete();
    drive_cycle(1, 0, 0, 1);
    drive_cycle(1, 0, 0, 1);
    sb.delete();
    first_valid_seen = 0;
    prev_hold = 0;
  endtask

  task automatic test_reset();
    int ptr;
    apply_reset();
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_keep !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_values: valid=%b data=%h keep=%b required 0 0 0", out_valid, out_data, out_keep);
    end
    fifo_q = '{8'h5A, 8'h5B};
    drive_cycle(0, 1, 0, 0);
    drive_cycle(0, 1, 0, 0);
    fifo_q = '{8'h10, 8'h11, 8'h12, 8'h13};
    ptr = got_data.size();
    drive_cycle(0, 1, 0, 1);
    n_checks++;
    if (last_rd_en !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: rd_en=%b valid=%b required 0 0", last_rd_en, out_valid);
    end
    for (int c = 0; c < 20 && got_data.size() == ptr; c++) drive_cycle(0, 1, 0, 0);
    n_checks++;
    if (got_data.size() != ptr + 1) begin
      n_fail++;
      $display("FAIL reset_beat_count: got %0d beats required 1", got_data.size() - ptr);
    end else if (got_data[ptr] !== 32'h13121110 || got_keep[ptr] !== 4'b1111) begin
      n_fail++;
      $display("FAIL reset_beat: got %h/%b required 13121110/1111", got_data[ptr], got_keep[ptr]);
    end
  endtask

  task automatic test_full_beat();
    int ptr;
    apply_reset();
    fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    ptr = got_data.size();
    for (int c = 0; c < 20 && got_data.size() == ptr; c++) drive_cycle(0, 1, 0, 0);
    n_checks++;
    if (got_data.size() != ptr + 1) begin
      n_fail++;
      $display("FAIL full_beat_count: got %0d beats required 1", got_data.size() - ptr);
    end else if (got_data[ptr] !== 32'h44332211 || got_keep[ptr] !== 4'b1111) begin
      n_fail++;
      $display("FAIL full_beat: got %h/%b required 44332211/1111", got_data[ptr], got_keep[ptr]);
    end
    n_checks++;
    if (first_valid_cyc != last_pop_cyc + 1) begin
      n_fail++;
      $display("FAIL latency: valid at cycle %0d required %0d", first_valid_cyc, last_pop_cyc + 1);
    end
  endtask

  task automatic test_backpressure();
    int ptr;
    int p0;
    apply_reset();
    fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    ptr = got_data.size();
    p0 = pops;
    for (int c = 0; c < 10; c++) begin
      drive_cycle(0, 0, 0, 0);
      if (c == 8) begin
        n_checks++;
        if (last_rd_en !== 1'b0 || pops - p0 != 7) begin
          n_fail++;
          $display("FAIL stall_limit: rd_en=%b pops=%0d required 0 7", last_rd_en, pops - p0);
        end
      end
    end
    for (int c = 0; c < 20 && got_data.size() < ptr + 2; c++) drive_cycle(0, 1, 0, 0);
    n_checks++;
    if (got_data.size() != ptr + 2) begin
      n_fail++;
      $display("FAIL bp_beat_count: got %0d beats required 2", got_data.size() - ptr);
    end else if (got_data[ptr] !== 32'h44332211 || got_data[ptr+1] !== 32'h88776655 ||
                 got_keep[ptr] !== 4'b1111 || got_keep[ptr+1] !== 4'b1111) begin
      n_fail++;
      $display("FAIL bp_beats: got %h/%b %h/%b required 44332211/1111 88776655/1111",
               got_data[ptr], got_keep[ptr], got_data[ptr+1], got_keep[ptr+1]);
    end
  endtask

  task automatic test_flush();
    int ptr;
    apply_reset();
    fifo_q = '{8'hAA, 8'hBB};
    ptr = got_data.size();
    drive_cycle(0, 1, 0, 0);
    drive_cycle(0, 1, 0, 0);
    drive_cycle(0, 1, 1, 0);
    for (int c = 0; c < 10 && got_data.size() == ptr; c++) drive_cycle(0, 1, 0, 0);
    n_checks++;
    if (got_data.size() != ptr + 1) begin
      n_fail++;
      $display("FAIL flush_beat_count: got %0d beats required 1", got_data.size() - ptr);
    end else if (got_data[ptr][15:0] !== 16'hBBAA || got_keep[ptr] !== 4'b0011) begin
      n_fail++;
      $display("FAIL flush_beat: got %h/%b required xxxxBBAA/0011", got_data[ptr], got_keep[ptr]);
    end
    ptr = got_data.size();
    drive_cycle(0, 1, 1, 0);
    for (int c = 0; c < 5; c++) drive_cycle(0, 1, 0, 0);
    n_checks++;
    if (got_data.size() != ptr || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_flush: got %0d beats valid=%b required 0 0", got_data.size() - ptr, out_valid);
    end
  endtask

  task automatic test_flush_with_pop();
    int ptr;
    apply_reset();
    fifo_q = '{8'h01, 8'h02, 8'h03};
    ptr = got_data.size();
    drive_cycle(0, 1, 0, 0);
    drive_cycle(0, 1, 0, 0);
    drive_cycle(0, 1, 1, 0);
    for (int c = 0; c < 10 && got_data.size() == ptr; c++) drive_cycle(0, 1, 0, 0);
    n_checks++;
    if (got_data.size() != ptr + 1) begin
      n_fail++;
      $display("FAIL flush_pop_count: got %0d beats required 1", got_data.size() - ptr);
    end else if (got_data[ptr][23:0] !== 24'h030201 || got_keep[ptr] !== 4'b0111) begin
      n_fail++;
      $display("FAIL flush_pop_beat: got %h/%b required xx030201/0111", got_data[ptr], got_keep[ptr]);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 10000; c++) begin
      if (fifo_q.size() < 4) fifo_q.push_back(8'($urandom));
      drive_cycle($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0, 0);
    end
    for (int c = 0; c < 100 && (sb.size() != 0 || fifo_q.size() != 0 || out_valid); c++)
      drive_cycle(0, 1, 1, 0);
    n_checks++;
    if (sb.size() != 0 || fifo_q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL random_drain: %0d words unreturned, %0d in fifo, valid=%b required 0 0 0",
               sb.size(), fifo_q.size(), out_valid);
    end
  endtask

  initial begin
    reset = 1'b1;
    fifo_rd_empty = 1'b1;
    fifo_rd_data = 8'h00;
    flush = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_full_beat();
    test_backpressure();
    test_flush();
    test_flush_with_pop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
